// File: rtl/cricket_pkg.sv
// Shared constants, innings state encoding and team-data layout for the
// cricket score keeper.
package cricket_pkg;

  // Match limits; widths match the tally registers they are compared against.
  localparam logic [6:0] MAX_BALLS   = 7'd120;
  localparam logic [3:0] MAX_WICKETS = 4'd10;
  localparam logic [7:0] MAX_RUNS    = 8'd255;

  // Largest runs value that can be scored off the bat in one delivery.
  localparam logic [2:0] MAX_BALL_RUNS = 3'd6;

  // Field offsets inside the 12-bit {runs, wickets} team-data word.
  localparam int RUNS_MSB    = 11;
  localparam int RUNS_LSB    = 4;
  localparam int WICKETS_MSB = 3;
  localparam int WICKETS_LSB = 0;

  // Innings progression of a two-team limited-overs match.
  typedef enum logic [1:0] {
    ST_INN1  = 2'd0,
    ST_BREAK = 2'd1,
    ST_INN2  = 2'd2,
    ST_DONE  = 2'd3
  } inning_state_t;

  // Pack a team's runs and wickets into the team-data layout.
  function automatic logic [11:0] pack_team(input logic [7:0] runs,
                                            input logic [3:0] wickets);
    logic [11:0] word;
    word = '0;
    word[RUNS_MSB:RUNS_LSB]       = runs;
    word[WICKETS_MSB:WICKETS_LSB] = wickets;
    return word;
  endfunction

endpackage

// File: rtl/team_tally.sv
// Runs / wickets / legal-ball tally for one team. All three counters
// saturate at their match limits. The post-update values are exported so
// the innings FSM can decide transitions on the same edge as the update.
module team_tally
  import cricket_pkg::*;
(
  input  logic       clk_fpga,
  input  logic       reset,
  input  logic       enable,
  input  logic [2:0] add_runs,
  input  logic       add_extra,
  input  logic       add_wicket,
  output logic [7:0] runs,
  output logic [3:0] wickets,
  output logic [6:0] balls,
  output logic [7:0] runs_nxt,
  output logic [3:0] wickets_nxt,
  output logic [6:0] balls_nxt
);

  logic [8:0] run_sum;

  // Next-state values of the three counters for the current delivery.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    run_sum     = {1'b0, runs} + {6'd0, add_runs} + {8'd0, add_extra};
    runs_nxt    = runs;
    wickets_nxt = wickets;
    balls_nxt   = balls;
    if (enable) begin
      // A wide/no-ball adds a penalty run but is not a legal delivery.
      runs_nxt = (run_sum > {1'b0, MAX_RUNS}) ? MAX_RUNS : run_sum[7:0];
      if (add_wicket && (wickets < MAX_WICKETS)) begin
        wickets_nxt = wickets + 4'd1;
      end
      if (!add_extra && (balls < MAX_BALLS)) begin
        balls_nxt = balls + 7'd1;
      end
    end
  end

  // Counter registers, cleared by the synchronous active-low reset.
  always_ff @(posedge clk_fpga) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; blocking here would create ordering races.
    if (!reset) begin
      runs    <= '0;
      wickets <= '0;
      balls   <= '0;
    end else begin
      runs    <= runs_nxt;
      wickets <= wickets_nxt;
      balls   <= balls_nxt;
    end
  end

endmodule

// File: rtl/score_keeper.sv
// Cricket match score keeper: accepts delivery events for the batting
// team, keeps per-team tallies, and sequences the two innings.
module score_keeper
  import cricket_pkg::*;
(
  input  logic        clk_fpga,
  input  logic        reset,
  input  logic        ball_valid,
  input  logic [2:0]  ball_runs,
  input  logic        ball_wicket,
  input  logic        ball_extra,
  input  logic        next_inning,
  input  logic        gameOver,
  output logic [11:0] team1Data,
  output logic [11:0] team2Data,
  output logic [6:0]  team1Balls,
  output logic [6:0]  team2Balls,
  output logic [3:0]  wickets,
  output logic [15:0] balls,
  output logic        batting_team,
  output logic        ball_ack,
  output logic        ball_nack,
  output logic        match_done
);

  inning_state_t state;

  logic [7:0] t1_runs, t2_runs, t1_runs_nxt, t2_runs_nxt;
  logic [3:0] t1_wickets, t2_wickets, t1_wickets_nxt, t2_wickets_nxt;
  logic [6:0] t1_balls, t2_balls, t1_balls_nxt, t2_balls_nxt;

  logic       in_play;
  logic [3:0] bat_wickets;
  logic [6:0] bat_balls;
  logic       accept;
  logic       t1_en;
  logic       t2_en;
  logic       inn1_over;
  logic       inn2_over;

  // Acceptance decision and per-team update enables for this cycle.
  always_comb begin
    in_play     = (state == ST_INN1) || (state == ST_INN2);
    bat_wickets = (state == ST_INN1) ? t1_wickets : t2_wickets;
    bat_balls   = (state == ST_INN1) ? t1_balls   : t2_balls;
    accept      = ball_valid && in_play &&
                  (ball_runs <= MAX_BALL_RUNS) &&
                  (bat_wickets < MAX_WICKETS) &&
                  (bat_balls < MAX_BALLS);
    t1_en       = accept && (state == ST_INN1);
    t2_en       = accept && (state == ST_INN2);
    // Innings-end conditions are judged on the values this edge will store.
    inn1_over   = (t1_wickets_nxt == MAX_WICKETS) || (t1_balls_nxt == MAX_BALLS);
    inn2_over   = (t2_wickets_nxt == MAX_WICKETS) || (t2_balls_nxt == MAX_BALLS) ||
                  (t2_runs_nxt > t1_runs_nxt) || gameOver;
  end

  team_tally u_team1 (
    .clk_fpga    (clk_fpga),
    .reset       (reset),
    .enable      (t1_en),
    .add_runs    (ball_runs),
    .add_extra   (ball_extra),
    .add_wicket  (ball_wicket),
    .runs        (t1_runs),
    .wickets     (t1_wickets),
    .balls       (t1_balls),
    .runs_nxt    (t1_runs_nxt),
    .wickets_nxt (t1_wickets_nxt),
    .balls_nxt   (t1_balls_nxt)
  );

  team_tally u_team2 (
    .clk_fpga    (clk_fpga),
    .reset       (reset),
    .enable      (t2_en),
    .add_runs    (ball_runs),
    .add_extra   (ball_extra),
    .add_wicket  (ball_wicket),
    .runs        (t2_runs),
    .wickets     (t2_wickets),
    .balls       (t2_balls),
    .runs_nxt    (t2_runs_nxt),
    .wickets_nxt (t2_wickets_nxt),
    .balls_nxt   (t2_balls_nxt)
  );

  // Innings FSM with registered handshake and status outputs.
  always_ff @(posedge clk_fpga) begin
    // NOTE: reset is synchronous, so it is just the highest-priority branch
    // inside the clocked block and is not in the sensitivity list.
    if (!reset) begin
      state        <= ST_INN1;
      batting_team <= 1'b0;
      match_done   <= 1'b0;
      ball_ack     <= 1'b0;
      ball_nack    <= 1'b0;
    end else begin
      ball_ack  <= accept;
      ball_nack <= ball_valid && !accept;
      case (state)
        ST_INN1: begin
          if (accept && inn1_over) begin
            state <= ST_BREAK;
          end
        end
        ST_BREAK: begin
          if (next_inning) begin
            state        <= ST_INN2;
            batting_team <= 1'b1;
          end
        end
        ST_INN2: begin
          if (inn2_over) begin
            state      <= ST_DONE;
            match_done <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_DONE;
        end
        default: begin
          state        <= ST_INN1;
          batting_team <= 1'b0;
          match_done   <= 1'b0;
        end
      endcase
    end
  end

  // Output packing and batting-team mirror.
  always_comb begin
    team1Data  = pack_team(t1_runs, t1_wickets);
    team2Data  = pack_team(t2_runs, t2_wickets);
    team1Balls = t1_balls;
    team2Balls = t2_balls;
    wickets    = batting_team ? t2_wickets : t1_wickets;
    balls      = {9'd0, (batting_team ? t2_balls : t1_balls)};
  end

endmodule

// File: tb/tb_score_keeper.sv
// Directed self-checking bench for score_keeper.
module tb_score_keeper;

  logic        clk_fpga;
  logic        reset;
  logic        ball_valid;
  logic [2:0]  ball_runs;
  logic        ball_wicket;
  logic        ball_extra;
  logic        next_inning;
  logic        gameOver;
  logic [11:0] team1Data;
  logic [11:0] team2Data;
  logic [6:0]  team1Balls;
  logic [6:0]  team2Balls;
  logic [3:0]  wickets;
  logic [15:0] balls;
  logic        batting_team;
  logic        ball_ack;
  logic        ball_nack;
  logic        match_done;

  int checks = 0;
  int errors = 0;

  score_keeper dut (
    .clk_fpga     (clk_fpga),
    .reset        (reset),
    .ball_valid   (ball_valid),
    .ball_runs    (ball_runs),
    .ball_wicket  (ball_wicket),
    .ball_extra   (ball_extra),
    .next_inning  (next_inning),
    .gameOver     (gameOver),
    .team1Data    (team1Data),
    .team2Data    (team2Data),
    .team1Balls   (team1Balls),
    .team2Balls   (team2Balls),
    .wickets      (wickets),
    .balls        (balls),
    .batting_team (batting_team),
    .ball_ack     (ball_ack),
    .ball_nack    (ball_nack),
    .match_done   (match_done)
  );

  initial clk_fpga = 1'b0;
  always #5 clk_fpga = ~clk_fpga;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Present one delivery for a single edge, then sample 1 ns after it.
  task automatic send(input logic [2:0] r, input logic w, input logic e);
    ball_valid  = 1'b1;
    ball_runs   = r;
    ball_wicket = w;
    ball_extra  = e;
    @(posedge clk_fpga);
    #1;
    ball_valid  = 1'b0;
    ball_runs   = 3'd0;
    ball_wicket = 1'b0;
    ball_extra  = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk_fpga);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk_fpga);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    reset       = 1'b0;
    ball_valid  = 1'b0;
    ball_runs   = 3'd0;
    ball_wicket = 1'b0;
    ball_extra  = 1'b0;
    next_inning = 1'b0;
    gameOver    = 1'b0;

    // ---------------- Match A ----------------
    do_reset();
    check("rst_team1Data", team1Data, 12'h000);
    check("rst_team2Data", team2Data, 12'h000);
    check("rst_team1Balls", team1Balls, 7'd0);
    check("rst_balls", balls, 16'd0);
    check("rst_ack", ball_ack, 1'b0);
    check("rst_nack", ball_nack, 1'b0);
    check("rst_done", match_done, 1'b0);
    check("rst_bat", batting_team, 1'b0);

    for (int i = 0; i < 6; i++) begin
      send(3'd4, 1'b0, 1'b0);
      check($sformatf("four_ack_%0d", i), ball_ack, 1'b1);
    end
    check("six_fours_data", team1Data, 12'h180);
    check("six_fours_balls", team1Balls, 7'd6);
    check("six_fours_mirror", balls, 16'd6);

    send(3'd2, 1'b0, 1'b1);
    check("extra_ack", ball_ack, 1'b1);
    check("extra_data", team1Data, 12'h1B0);
    check("extra_balls", team1Balls, 7'd6);

    send(3'd7, 1'b0, 1'b0);
    check("runs7_nack", ball_nack, 1'b1);
    check("runs7_ack", ball_ack, 1'b0);
    check("runs7_data", team1Data, 12'h1B0);

    idle();
    check("idle_ack", ball_ack, 1'b0);
    check("idle_nack", ball_nack, 1'b0);

    send(3'd0, 1'b1, 1'b1);
    check("stumped_wide_data", team1Data, 12'h1C1);
    check("stumped_wide_balls", team1Balls, 7'd6);
    check("stumped_wide_wkts", wickets, 4'd1);

    gameOver    = 1'b1;
    next_inning = 1'b1;
    idle();
    gameOver    = 1'b0;
    next_inning = 1'b0;
    idle();
    check("inn1_gameover_bat", batting_team, 1'b0);
    check("inn1_gameover_done", match_done, 1'b0);
    send(3'd0, 1'b0, 1'b0);
    check("inn1_still_live", ball_ack, 1'b1);

    for (int i = 0; i < 9; i++) send(3'd0, 1'b1, 1'b0);
    check("allout_data", team1Data, 12'h1CA);
    check("allout_balls", team1Balls, 7'd16);
    check("allout_bat", batting_team, 1'b0);

    send(3'd4, 1'b0, 1'b0);
    check("break_nack", ball_nack, 1'b1);
    check("break_data", team1Data, 12'h1CA);
    check("break_t2", team2Data, 12'h000);

    next_inning = 1'b1;
    send(3'd4, 1'b0, 1'b0);
    next_inning = 1'b0;
    check("ni_ball_nack", ball_nack, 1'b1);
    check("ni_bat", batting_team, 1'b1);
    check("ni_wkts", wickets, 4'd0);
    check("ni_balls", balls, 16'd0);
    check("ni_t2", team2Data, 12'h000);

    send(3'd4, 1'b0, 1'b0);
    check("inn2_ack", ball_ack, 1'b1);
    check("inn2_t2", team2Data, 12'h040);
    check("inn2_t2balls", team2Balls, 7'd1);
    check("inn2_done0", match_done, 1'b0);

    gameOver = 1'b1;
    idle();
    gameOver = 1'b0;
    check("gameover_done", match_done, 1'b1);
    send(3'd4, 1'b0, 1'b0);
    check("done_nack", ball_nack, 1'b1);
    check("done_t2", team2Data, 12'h040);
    check("done_hold", match_done, 1'b1);

    reset = 1'b0;
    idle();
    check("rst_in_done", match_done, 1'b0);
    check("rst_in_done_t1", team1Data, 12'h000);
    check("rst_in_done_bat", batting_team, 1'b0);
    reset = 1'b1;

    // ---------------- Match B: reset mid-INN2 ----------------
    for (int i = 0; i < 10; i++) send(3'd0, 1'b1, 1'b0);
    next_inning = 1'b1;
    idle();
    next_inning = 1'b0;
    send(3'd3, 1'b0, 1'b0);
    check("b_t2", team2Data, 12'h030);
    check("b_bat", batting_team, 1'b1);
    reset = 1'b0;
    send(3'd5, 1'b0, 1'b0);
    reset = 1'b1;
    check("b_rst_t1", team1Data, 12'h000);
    check("b_rst_t2", team2Data, 12'h000);
    check("b_rst_t1balls", team1Balls, 7'd0);
    check("b_rst_t2balls", team2Balls, 7'd0);
    check("b_rst_ack", ball_ack, 1'b0);
    check("b_rst_nack", ball_nack, 1'b0);
    check("b_rst_bat", batting_team, 1'b0);
    send(3'd1, 1'b0, 1'b0);
    check("b_back_in_inn1", team1Data, 12'h010);

    // ---------------- Match C: chase ----------------
    do_reset();
    for (int i = 0; i < 8; i++) send(3'd6, 1'b0, 1'b0);
    send(3'd2, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) send(3'd0, 1'b1, 1'b0);
    check("c_t1", team1Data, 12'h32A);
    check("c_t1balls", team1Balls, 7'd19);
    next_inning = 1'b1;
    idle();
    next_inning = 1'b0;
    for (int i = 0; i < 8; i++) send(3'd6, 1'b0, 1'b0);
    check("c_t2_48", team2Data, 12'h300);
    send(3'd2, 1'b0, 1'b0);
    check("c_tie_done", match_done, 1'b0);
    send(3'd1, 1'b0, 1'b0);
    check("c_t2_51", team2Data, 12'h330);
    check("c_chase_done", match_done, 1'b1);
    send(3'd1, 1'b0, 1'b0);
    check("c_after_nack", ball_nack, 1'b1);
    check("c_after_t2", team2Data, 12'h330);

    // ---------------- Match D: saturation and ball limit ----------------
    do_reset();
    for (int i = 0; i < 36; i++) send(3'd6, 1'b0, 1'b1);
    check("d_252", team1Data, 12'hFC0);
    check("d_252_balls", team1Balls, 7'd0);
    send(3'd6, 1'b0, 1'b0);
    check("d_sat", team1Data, 12'hFF0);
    send(3'd1, 1'b0, 1'b0);
    check("d_sat_nowrap", team1Data, 12'hFF0);
    for (int i = 0; i < 118; i++) send(3'd0, 1'b0, 1'b0);
    check("d_120_balls", team1Balls, 7'd120);
    check("d_120_ack", ball_ack, 1'b1);
    send(3'd0, 1'b0, 1'b0);
    check("d_121_nack", ball_nack, 1'b1);
    check("d_121_balls", team1Balls, 7'd120);
    next_inning = 1'b1;
    idle();
    next_inning = 1'b0;
    check("d_break_to_inn2", batting_team, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
